// File: rtl/fetch_pkg.sv
//==============================================================================
// Module      : fetch_pkg
// Description : Shared state encoding, default constants and helpers for the
//               instruction-fetch controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    localparam logic [15:0] c_PC_INC_DEFAULT  = 16'd2;
    localparam logic [3:0]  c_HLT_OPC_DEFAULT = 4'hF;

    // Instructions are halfword aligned, so bit 0 of a redirect is dropped.
    function automatic logic [15:0] align_target(input logic [15:0] target);
        return target & ~16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_buf.sv
//==============================================================================
// Module      : fetch_buf
// Description : One-entry instruction buffer between fetch and decode with
//               load, drain and flush controls (flush > load > drain).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_data,
    input  logic        drain,
    input  logic        flush,
    output logic [15:0] data,
    output logic        valid
);

    logic [15:0] r_data;
    logic        r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= 16'd0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_valid <= 1'b1;
        end else if (drain) begin
            r_valid <= 1'b0;
        end
    end

    assign data  = r_data;
    assign valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
//==============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch controller: drives the PC register and the
//               instruction-memory handshake, handles redirects and halt.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [15:0] PC_INC  = c_PC_INC_DEFAULT,
    parameter logic [3:0]  HLT_OPC = c_HLT_OPC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    output logic [15:0] pc_next,
    output logic        pc_en,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target
);

    fetch_state_t r_state;
    logic         r_pending;
    logic [15:0]  r_target;

    logic         w_in_fetch;
    logic         w_active;
    logic         w_drain;
    logic         w_req;
    logic         w_ack;
    logic         w_redir_en;
    logic [15:0]  w_redir_tgt;
    logic         w_load;
    logic         w_flush;
    logic         w_is_hlt;

    assign w_in_fetch = (r_state == ST_FETCH);
    assign w_active   = w_in_fetch || (r_state == ST_HALTED);
    assign w_drain    = instr_valid && !stall;

    // A request stays up until acked: once the buffer is empty it can only
    // refill through that ack, and a redirect flushes it rather than filling.
    assign w_req      = w_in_fetch && (!instr_valid || !stall);
    assign w_ack      = w_req && imem_ack;

    // A live branch beats a pending one; an ack carrying a redirect is wrong-path.
    assign w_redir_en  = (branch_taken && w_active && !w_req) ||
                         (w_ack && (branch_taken || r_pending));
    assign w_redir_tgt = branch_taken ? align_target(branch_target) : r_target;
    assign w_load      = w_ack && !branch_taken && !r_pending;
    assign w_flush     = branch_taken && w_active;
    assign w_is_hlt    = (imem_data[15:12] == HLT_OPC);

    always_comb begin
        pc_next = 16'd0;
        if (w_redir_en) begin
            pc_next = w_redir_tgt;
        end else if (w_load) begin
            pc_next = pc + PC_INC;
        end
    end

    assign pc_en     = w_redir_en || w_load;
    assign imem_req  = w_req;
    assign imem_addr = w_req ? pc : 16'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
            r_target  <= 16'd0;
        end else begin
            if (w_ack) begin
                r_pending <= 1'b0;
            end else if (branch_taken && w_req) begin
                r_pending <= 1'b1;
                r_target  <= align_target(branch_target);
            end

            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (w_load && w_is_hlt) begin
                        r_state <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    if (branch_taken) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .load_data (imem_data),
        .drain     (w_drain),
        .flush     (w_flush),
        .data      (instr),
        .valid     (instr_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
//==============================================================================
// Module      : tb_fetch_ctrl
// Description : Scoreboard bench for fetch_ctrl with a behavioural PC register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic        pc_en;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'd0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'd0;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_pc[$];
    logic [15:0] exp_instr[$];

    fetch_ctrl #(.PC_INC(16'd2), .HLT_OPC(4'hF)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .pc_next       (pc_next),
        .pc_en         (pc_en),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    always #5 clk = ~clk;

    // External PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        pc <= 16'd0;
        else if (pc_en) pc <= pc_next;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every pc_en and every instruction consumed by decode is scored.
    always @(negedge clk) begin
        if (!rst) begin
            if (pc_en) begin
                if (exp_pc.size() == 0) chk("pc_en_unexpected", {15'd0, pc_en}, 16'd0);
                else                    chk("pc_next", pc_next, exp_pc.pop_front());
            end
            if (instr_valid && !stall) begin
                if (exp_instr.size() == 0) chk("instr_unexpected", {15'd0, instr_valid}, 16'd0);
                else                       chk("instr", instr, exp_instr.pop_front());
            end
        end
    end

    task automatic step(input logic a, input logic [15:0] d, input logic s,
                        input logic b, input logic [15:0] t, input logic exp_req);
        imem_ack = a; imem_data = d; stall = s; branch_taken = b; branch_target = t;
        @(negedge clk);
        chk("imem_req", {15'd0, imem_req}, {15'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, pc);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pc_next"}, pc_next, 16'd0);
        chk({tag, "_pc_en"}, {15'd0, pc_en}, 16'd0);
        chk({tag, "_imem_req"}, {15'd0, imem_req}, 16'd0);
        chk({tag, "_imem_addr"}, imem_addr, 16'd0);
        chk({tag, "_instr"}, instr, 16'd0);
        chk({tag, "_instr_valid"}, {15'd0, instr_valid}, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // IDLE for one cycle after reset release
        step(0, 16'h0000, 0, 0, 16'h0, 0);

        // Sequential fetch 0,2,4 with back-to-back acks
        exp_pc.push_back(16'h0002); exp_instr.push_back(16'h1001);
        step(1, 16'h1001, 0, 0, 16'h0, 1);
        exp_pc.push_back(16'h0004); exp_instr.push_back(16'h1002);
        step(1, 16'h1002, 0, 0, 16'h0, 1);
        exp_pc.push_back(16'h0006); exp_instr.push_back(16'h1003);
        step(1, 16'h1003, 0, 0, 16'h0, 1);

        // Stall holds buffer and suppresses requests
        for (int i = 0; i < 3; i++) begin
            step(0, 16'h0000, 1, 0, 16'h0, 0);
            chk("stall_instr", instr, 16'h1003);
            chk("stall_valid", {15'd0, instr_valid}, 16'd1);
        end
        exp_pc.push_back(16'h0008); exp_instr.push_back(16'h2001);
        step(1, 16'h2001, 0, 0, 16'h0, 1);

        // Branch during outstanding request, ack two cycles later
        step(0, 16'h0000, 0, 1, 16'h0041, 1);
        step(0, 16'h0000, 0, 0, 16'h0, 1);
        exp_pc.push_back(16'h0040);
        step(1, 16'h3333, 0, 0, 16'h0, 1);
        chk("discard_valid", {15'd0, instr_valid}, 16'd0);

        // Second branch overwrites the pending target
        step(0, 16'h0000, 0, 1, 16'h0100, 1);
        step(0, 16'h0000, 0, 1, 16'h0203, 1);
        exp_pc.push_back(16'h0202);
        step(1, 16'h3334, 0, 0, 16'h0, 1);

        // PC wrap at 16'hFFFE
        step(0, 16'h0000, 0, 1, 16'hFFFF, 1);
        exp_pc.push_back(16'hFFFE);
        step(1, 16'h4444, 0, 0, 16'h0, 1);
        exp_pc.push_back(16'h0000); exp_instr.push_back(16'h4321);
        step(1, 16'h4321, 0, 0, 16'h0, 1);

        // Branch coincident with ack: redirect wins
        exp_pc.push_back(16'h0080);
        step(1, 16'h5555, 0, 1, 16'h0080, 1);
        chk("coincident_valid", {15'd0, instr_valid}, 16'd0);

        // Halt, then redirect out of HALTED
        exp_pc.push_back(16'h0082); exp_instr.push_back(16'hF000);
        step(1, 16'hF000, 0, 0, 16'h0, 1);
        chk("hlt_instr", instr, 16'hF000);
        step(0, 16'h0000, 1, 0, 16'h0, 0);
        step(0, 16'h0000, 0, 0, 16'h0, 0);
        step(0, 16'h0000, 0, 0, 16'h0, 0);
        step(1, 16'h1234, 0, 0, 16'h0, 0);
        exp_pc.push_back(16'h0010);
        step(0, 16'h0000, 0, 1, 16'h0010, 0);
        exp_pc.push_back(16'h0012); exp_instr.push_back(16'h6000);
        step(1, 16'h6000, 0, 0, 16'h0, 1);

        // Reset pulse mid-request; late ack ignored in IDLE
        step(0, 16'h0000, 0, 0, 16'h0, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, 16'h7777, 0, 0, 16'h0, 0);
        exp_pc.push_back(16'h0002); exp_instr.push_back(16'h1111);
        step(1, 16'h1111, 0, 0, 16'h0, 1);
        step(0, 16'h0000, 0, 0, 16'h0, 1);

        chk("pc_queue_empty", 16'(exp_pc.size()), 16'd0);
        chk("instr_queue_empty", 16'(exp_instr.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The module SHALL have parameter PC_INC, default 16'd2: byte increment between sequential fetches.
REQ-002 The module SHALL have parameter HLT_OPC, default 4'hF: opcode in instr[15:12] that halts fetch.
REQ-003 The module SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port pc  input  16  current PC from the PC register.
REQ-006 The module SHALL have port pc_next  output  16  value to load into the PC register.
REQ-007 The module SHALL have port pc_en  output  1  PC register write enable.
REQ-008 The module SHALL have port imem_req  output  1  instruction-memory request, held until ack.
REQ-009 The module SHALL have port imem_addr  output  16  request address, equal to pc while imem_req=1.
REQ-010 The module SHALL have port imem_ack  input  1  one-cycle acknowledge with imem_data valid.
REQ-011 The module SHALL have port imem_data  input  16  fetched instruction word.
REQ-012 The module SHALL have port instr  output  16  buffered instruction to decode.
REQ-013 The module SHALL have port instr_valid  output  1  instr holds a live instruction.
REQ-014 The module SHALL have port stall  input  1  decode cannot accept; instr held while instr_valid=1.
REQ-015 The module SHALL have port branch_taken  input  1  one-cycle redirect pulse from execute.
REQ-016 The module SHALL have port branch_target  input  16  redirect address.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, HALTED; IDLE moves to FETCH on the first clock after reset release.
REQ-018 In FETCH, imem_req SHALL be 1 only when the output buffer is empty or drains this cycle (instr_valid=1, stall=0).
REQ-019 On imem_ack with no redirect, the module SHALL load imem_data into instr, set instr_valid on the next edge, and assert pc_en with pc_next = pc + PC_INC in the ack cycle.
REQ-020 pc_next arithmetic SHALL wrap modulo 2^16 (16'hFFFE + 2 = 16'h0000).
REQ-021 The buffer SHALL hold instr and instr_valid unchanged while stall=1; it clears on a drain with no new ack.
REQ-022 branch_taken with no request outstanding SHALL assert pc_en with pc_next = {branch_target[15:1],1'b0} in that cycle and clear instr_valid on the next edge.
REQ-023 branch_taken while a request is outstanding SHALL record a pending redirect (target latched); imem_req stays high until ack.
REQ-024 An ack with a redirect pending or branch_taken in the same cycle SHALL discard imem_data, apply the redirect via pc_en/pc_next, and clear the pending flag.
REQ-025 A second branch_taken while a redirect is pending SHALL overwrite the latched target.
REQ-026 Capturing an instruction with instr[15:12] = HLT_OPC SHALL move the FSM to HALTED; the HLT word is still presented on instr.
REQ-027 In HALTED, imem_req and pc_en SHALL be 0; branch_taken SHALL redirect and return to FETCH.
REQ-028 pc_en SHALL never assert for two sources in one cycle; redirect overrides increment.

Reset
REQ-029 While rst=1, state SHALL be IDLE and pc_next, pc_en, imem_req, instr, instr_valid, pending flag and target SHALL be 0.
REQ-030 rst asserted mid-request SHALL abandon it; a late imem_ack after reset release SHALL be ignored in IDLE.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum, default HLT_OPC and PC_INC constants.
REQ-032 The one-entry output buffer SHALL be sub-module fetch_buf (load, drain, flush).

Verification
REQ-033 Reset release, pc=0, ack each cycle, stall=0 -> addresses 0,2,4; pc_en each ack; instr_valid one cycle after each ack.
REQ-034 stall=1 for 3 cycles with instr_valid=1 -> instr stable, imem_req=0, pc_en=0; fetch resumes the cycle stall drops.
REQ-035 branch_taken to 16'h0041 during outstanding request, ack 2 cycles later -> data discarded, pc_next=16'h0040, pc_en=1 on ack.
REQ-036 pc=16'hFFFE, ack -> pc_next=16'h0000.
REQ-037 Fetched word 16'hF000 -> instr_valid=1, HALTED, no imem_req; branch_taken to 16'h0010 -> FETCH, imem_addr follows pc.
REQ-038 rst pulse while imem_req=1 -> all outputs 0 immediately; ack in the next cycle ignored.
